// File: rtl/wb_burst_master_pkg.sv
// Shared SDRAM-controller types and constants.
// Adds the Wishbone burst master state type and CTI codes.
package sdrctrl_package;

  localparam int aw = 26;
  localparam int dw = 32;

  typedef enum logic [1:0] {
    INIT,
    IDLE,
    XFER,
    RESP
  } wbm_state_t;

  localparam logic [2:0] WB_CTI_CLASSIC = 3'b000;
  localparam logic [2:0] WB_CTI_INCR    = 3'b010;
  localparam logic [2:0] WB_CTI_EOB     = 3'b111;

endpackage

// File: rtl/wb_burst_master_watchdog.sv
// Ack watchdog: counts strobe cycles without an ack.
// Flags expiry on the TIMEOUT_CYC-th unanswered cycle.
module wb_ack_watchdog #(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic sys_clk,
  input  logic RESETN,
  input  logic i_stb,
  input  logic i_ack,
  output logic o_expired
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] r_cnt;

  // A low strobe clears the count, so each new assertion starts at zero
  always_ff @(posedge sys_clk or negedge RESETN) begin
    if (!RESETN) begin
      r_cnt <= '0;
    end else if (!i_stb || i_ack) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expired = i_stb && !i_ack &&
                     (r_cnt == CW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/wb_burst_master.sv
// Wishbone B3 burst master feeding the SDRAM controller slave port.
// WB_MASTER_TIMEOUT_EN adds an ack watchdog that ends the cycle with err.
module wb_burst_master
  import sdrctrl_package::*;
#(
  parameter int AW          = aw,
  parameter int DW          = dw,
  parameter int MAX_BURST   = 16,
  parameter int TIMEOUT_CYC = 1024,
  parameter int LW          = $clog2(MAX_BURST)
) (
  input  logic            sys_clk,
  input  logic            RESETN,
  input  logic            sdr_init_done,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_we,
  input  logic [AW-1:0]   cmd_addr,
  input  logic [LW-1:0]   cmd_len,
  input  logic [DW/8-1:0] cmd_sel,
  input  logic [DW-1:0]   wdata,
  input  logic            wdata_valid,
  output logic            wdata_ready,
  output logic [DW-1:0]   rdata,
  output logic            rdata_valid,
  output logic            done,
  output logic            err,
  output logic            wb_cyc_i,
  output logic            wb_stb_i,
  output logic            wb_we_i,
  output logic [AW-1:0]   wb_addr_i,
  output logic [DW-1:0]   wb_dat_i,
  output logic [DW/8-1:0] wb_sel_i,
  output logic [2:0]      wb_cti_i,
  input  logic            wb_ack_o,
  input  logic [DW-1:0]   wb_dat_o
);

  localparam int          SW   = DW / 8;
  localparam logic [AW-1:0] STEP = AW'(SW);

  wbm_state_t    r_state;
  logic          r_we;
  logic          r_burst;
  logic          r_cyc;
  logic          r_stb;
  logic          r_rvalid;
  logic          r_done;
  logic          r_err;
  logic [AW-1:0] r_addr;
  logic [SW-1:0] r_sel;
  logic [LW-1:0] r_cnt;
  logic [DW-1:0] r_dat;
  logic [DW-1:0] r_rdata;

  logic w_ack;
  logic w_last;
  logic w_wready;
  logic w_load;
  logic w_expired;

  assign w_ack    = r_stb && wb_ack_o;
  assign w_last   = (r_cnt == '0);
  assign w_wready = (r_state == XFER) && r_we &&
                    (!r_stb || (wb_ack_o && !w_last));
  assign w_load   = w_wready && wdata_valid;

`ifdef WB_MASTER_TIMEOUT_EN
  wb_ack_watchdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_wdog (
    .sys_clk  (sys_clk),
    .RESETN   (RESETN),
    .i_stb    (r_stb),
    .i_ack    (wb_ack_o),
    .o_expired(w_expired)
  );
`else
  logic w_unused;
  assign w_unused  = (TIMEOUT_CYC > 0);
  assign w_expired = 1'b0;
`endif

  always_ff @(posedge sys_clk or negedge RESETN) begin
    if (!RESETN) begin
      r_state  <= INIT;
      r_we     <= 1'b0;
      r_burst  <= 1'b0;
      r_cyc    <= 1'b0;
      r_stb    <= 1'b0;
      r_rvalid <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_addr   <= '0;
      r_sel    <= '0;
      r_cnt    <= '0;
      r_dat    <= '0;
      r_rdata  <= '0;
    end else begin
      r_rvalid <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      unique case (r_state)
        INIT: begin
          if (sdr_init_done) r_state <= IDLE;
        end
        IDLE: begin
          if (cmd_valid) begin
            r_we    <= cmd_we;
            r_addr  <= cmd_addr;
            r_sel   <= cmd_sel;
            r_cnt   <= cmd_len;
            r_burst <= |cmd_len;
            r_cyc   <= 1'b1;
            r_stb   <= !cmd_we;
            r_state <= XFER;
          end
        end
        XFER: begin
          if (w_ack) begin
            r_addr <= r_addr + STEP;
            if (!r_we) begin
              r_rdata  <= wb_dat_o;
              r_rvalid <= 1'b1;
            end
            if (w_last) begin
              r_cyc   <= 1'b0;
              r_stb   <= 1'b0;
              r_done  <= 1'b1;
              r_state <= RESP;
            end else begin
              r_cnt <= r_cnt - 1'b1;
              // A write beat without fresh data opens a strobe gap
              if (r_we) r_stb <= wdata_valid;
            end
          end else if (w_expired) begin
            r_cyc   <= 1'b0;
            r_stb   <= 1'b0;
            r_done  <= 1'b1;
            r_err   <= 1'b1;
            r_state <= RESP;
          end
          if (w_load) begin
            r_dat <= wdata;
            r_stb <= 1'b1;
          end
        end
        RESP: begin
          r_state <= sdr_init_done ? IDLE : INIT;
        end
        default: r_state <= INIT;
      endcase
    end
  end

  assign cmd_ready   = (r_state == IDLE);
  assign wdata_ready = w_wready;
  assign rdata       = r_rdata;
  assign rdata_valid = r_rvalid;
  assign done        = r_done;
  assign err         = r_err;
  assign wb_cyc_i    = r_cyc;
  assign wb_stb_i    = r_stb;
  assign wb_we_i     = r_we;
  assign wb_addr_i   = r_addr;
  assign wb_dat_i    = r_dat;
  assign wb_sel_i    = r_sel;
  assign wb_cti_i    = (!r_cyc || !r_burst) ? WB_CTI_CLASSIC :
                       w_last ? WB_CTI_EOB : WB_CTI_INCR;

endmodule
